// File: rtl/led_activity_ctrl_if.sv
// Bundle of per-channel LED controls and status for led_activity_ctrl.
// The master side supplies mode/act/gate, and the slave (the controller) returns led/busy.
interface led_activity_ctrl_if #(
    parameter int CHANNELS = 2
);
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   act;
    logic [CHANNELS-1:0]   gate;
    logic [CHANNELS-1:0]   led;
    logic [CHANNELS-1:0]   busy;

    modport master (
        output mode,
        output act,
        output gate,
        input  led,
        input  busy
    );

    modport slave (
        input  mode,
        input  act,
        input  gate,
        output led,
        output busy
    );
endinterface

// File: rtl/led_activity_ctrl.sv
// Multi-channel LED driver with four per-channel modes: off, solid, breathe, activity.
// Each channel has an activity flash FSM (IDLE/ON/GAP). Events that arrive during a flash
// collapse into a single follow-up flash. All breathing channels share one free-running
// counter, so they stay in phase.
module led_activity_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int PWM_W      = 8,
    parameter int CNT_W      = 27,
    parameter int ON_LEN     = 1000000,
    parameter int GAP_LEN    = 500000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk_sys,
    input  logic               reset,
    led_activity_ctrl_if.slave bus
);
    localparam int MAX_LEN = (ON_LEN > GAP_LEN) ? ON_LEN : GAP_LEN;
    localparam int DCNT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [DCNT_W-1:0]   ON_LOAD  = DCNT_W'(ON_LEN - 1);
    localparam logic [DCNT_W-1:0]   GAP_LOAD = DCNT_W'(GAP_LEN - 1);
    localparam logic [DCNT_W-1:0]   DCNT_ONE = DCNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CHANNELS-1:0] LED_POL  = {CHANNELS{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [CNT_W-1:0]    cnt;
    state_t              state [CHANNELS];
    logic [DCNT_W-1:0]   dcnt  [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] lit;
    logic [CHANNELS-1:0] busy_d;
    logic                breathe;

    // Triangle-wave brightness. In the first half-period the duty rises with bright.
    // In the second half the compare is inverted, so the duty falls back.
    function automatic logic breathe_lit(input logic             phase,
                                         input logic [PWM_W-1:0] bright,
                                         input logic [PWM_W-1:0] pwm);
        return phase ? (bright <= pwm) : (bright > pwm);
    endfunction

    assign breathe = breathe_lit(cnt[CNT_W-1], cnt[CNT_W-2 -: PWM_W], cnt[PWM_W-1:0]);

    // Shared free-running counter for the breathe waveform.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Per-channel lit decision from the current mode, FSM state and shared counter.
    always_comb begin
        lit    = '0;
        busy_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (bus.mode[2*i +: 2])
                2'b00:   lit[i] = 1'b0;
                2'b01:   lit[i] = 1'b1;
                2'b10:   lit[i] = breathe;
                default: lit[i] = (state[i] == ON);
            endcase
            busy_d[i] = (state[i] != IDLE);
        end
    end

    // Activity FSMs plus registered led/busy outputs. The FSMs run regardless of mode/gate.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= IDLE;
                dcnt[i]  <= '0;
            end
            pending  <= '0;
            bus.led  <= LED_POL;
            bus.busy <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (state[i])
                    IDLE: begin
                        if (bus.act[i]) begin
                            state[i] <= ON;
                            dcnt[i]  <= ON_LOAD;
                        end
                    end
                    ON: begin
                        // Events during ON only queue a follow-up flash; they never stretch this one.
                        pending[i] <= pending[i] | bus.act[i];
                        if (dcnt[i] == '0) begin
                            state[i] <= GAP;
                            dcnt[i]  <= GAP_LOAD;
                        end else begin
                            dcnt[i] <= dcnt[i] - DCNT_ONE;
                        end
                    end
                    GAP: begin
                        if (dcnt[i] == '0) begin
                            // An event on the exit cycle counts the same as a queued one.
                            if (pending[i] || bus.act[i]) begin
                                state[i]   <= ON;
                                dcnt[i]    <= ON_LOAD;
                                pending[i] <= 1'b0;
                            end else begin
                                state[i] <= IDLE;
                            end
                        end else begin
                            dcnt[i]    <= dcnt[i] - DCNT_ONE;
                            pending[i] <= pending[i] | bus.act[i];
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                    end
                endcase
            end
            bus.led  <= (bus.gate & lit) ^ LED_POL;
            bus.busy <= busy_d;
        end
    end
endmodule

// File: tb/tb_led_activity_ctrl.sv
// Randomized plus directed bench for led_activity_ctrl.
// Two instances with different parameter sets are compared against a position-in-flash
// reference model.
module tb_led_activity_ctrl;
    localparam int CH_T  [2] = '{2, 3};
    localparam int PWM_T [2] = '{2, 3};
    localparam int CNT_T [2] = '{5, 8};
    localparam int ON_T  [2] = '{4, 3};
    localparam int GAP_T [2] = '{2, 5};
    localparam int AL_T  [2] = '{1, 0};

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    led_activity_ctrl_if #(.CHANNELS(2)) bus_a ();
    led_activity_ctrl_if #(.CHANNELS(3)) bus_b ();

    led_activity_ctrl #(
        .CHANNELS(2), .PWM_W(2), .CNT_W(5), .ON_LEN(4), .GAP_LEN(2), .ACTIVE_LOW(1)
    ) dut_a (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus_a)
    );

    led_activity_ctrl #(
        .CHANNELS(3), .PWM_W(3), .CNT_W(8), .ON_LEN(3), .GAP_LEN(5), .ACTIVE_LOW(0)
    ) dut_b (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    // Reference state: position within the current flash period (-1 = no flash running).
    int          pos  [2][8];
    bit          pend [2][8];
    int unsigned mcnt [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit ref_breathe(input int k, input int unsigned c);
        int unsigned levels = 1 << PWM_T[k];
        int unsigned bright = (c >> (CNT_T[k] - 1 - PWM_T[k])) % levels;
        int unsigned pwm    = c % levels;
        bit          phase  = ((c >> (CNT_T[k] - 1)) & 1) != 0;
        return phase ? (bright <= pwm) : (bright > pwm);
    endfunction

    // Predict the outputs after the coming edge, then advance the model across that edge.
    task automatic model_edge(input int k, input logic rst, input logic [15:0] mode,
                              input logic [7:0] act, input logic [7:0] gate,
                              output logic [7:0] e_led, output logic [7:0] e_busy);
        int period = ON_T[k] + GAP_T[k];
        bit lit;
        e_led  = '0;
        e_busy = '0;
        for (int i = 0; i < CH_T[k]; i++) begin
            if (rst) begin
                e_led[i]   = (AL_T[k] != 0);
                pos[k][i]  = -1;
                pend[k][i] = 1'b0;
            end else begin
                case (mode[2*i +: 2])
                    2'b00:   lit = 1'b0;
                    2'b01:   lit = 1'b1;
                    2'b10:   lit = ref_breathe(k, mcnt[k]);
                    default: lit = (pos[k][i] >= 0) && (pos[k][i] < ON_T[k]);
                endcase
                e_led[i]  = (gate[i] & lit) ^ (AL_T[k] != 0);
                e_busy[i] = (pos[k][i] >= 0);
                if (pos[k][i] < 0) begin
                    if (act[i]) pos[k][i] = 0;
                end else if (pos[k][i] == period - 1) begin
                    if (pend[k][i] || act[i]) begin
                        pos[k][i]  = 0;
                        pend[k][i] = 1'b0;
                    end else begin
                        pos[k][i] = -1;
                    end
                end else begin
                    if (act[i]) pend[k][i] = 1'b1;
                    pos[k][i]++;
                end
            end
        end
        mcnt[k] = rst ? 0 : ((mcnt[k] + 1) & ((1 << CNT_T[k]) - 1));
    endtask

    task automatic rand_b();
        bus_b.mode = 6'($urandom);
        bus_b.act  = 3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7));
        bus_b.gate = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b111;
    endtask

    // One clock: predict, step, compare both instances, re-randomize instance B.
    task automatic cycle();
        logic [7:0] ea_led, ea_busy, eb_led, eb_busy;
        model_edge(0, reset, 16'(bus_a.mode), 8'(bus_a.act), 8'(bus_a.gate), ea_led, ea_busy);
        model_edge(1, reset, 16'(bus_b.mode), 8'(bus_b.act), 8'(bus_b.gate), eb_led, eb_busy);
        @(posedge clk_sys);
        #1;
        cyc++;
        check_val("a_led",  32'(bus_a.led),  32'(ea_led));
        check_val("a_busy", 32'(bus_a.busy), 32'(ea_busy));
        check_val("b_led",  32'(bus_b.led),  32'(eb_led));
        check_val("b_busy", 32'(bus_b.busy), 32'(eb_busy));
        rand_b();
    endtask

    task automatic settle(input int n);
        bus_a.act = 2'b00;
        for (int j = 0; j < n; j++) cycle();
    endtask

    initial begin
        logic [7:0]  flash_pat;
        logic [7:0]  busy_pat;
        int          lit_cnt;
        int unsigned c;

        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < 8; i++) begin
                pos[k][i]  = -1;
                pend[k][i] = 1'b0;
            end
        end
        reset      = 1'b1;
        bus_a.mode = '0;
        bus_a.act  = '0;
        bus_a.gate = '0;
        rand_b();

        // Reset held 3 cycles, with activity requested on A to show that reset wins.
        bus_a.mode = 4'b1111;
        bus_a.act  = 2'b11;
        bus_a.gate = 2'b11;
        for (int j = 0; j < 3; j++) cycle();
        check_val("rst_led_a",  32'(bus_a.led),  32'h3);
        check_val("rst_busy_a", 32'(bus_a.busy), 32'h0);
        check_val("rst_led_b",  32'(bus_b.led),  32'h0);
        reset     = 1'b0;
        bus_a.act = 2'b00;
        cycle();
        check_val("idle_busy_a", 32'(bus_a.busy), 32'h0);

        // Single flash on channel 0: 4 lit, 2 dark, then idle.
        flash_pat = 8'b0001_1110;
        busy_pat  = 8'b0111_1110;
        for (int j = 0; j < 8; j++) begin
            bus_a.act = (j == 0) ? 2'b01 : 2'b00;
            cycle();
            check_val("flash_led",  32'(bus_a.led[0] ^ 1'b1), 32'(flash_pat[j]));
            check_val("flash_busy", 32'(bus_a.busy[0]),       32'(busy_pat[j]));
        end

        // Continuous activity on channel 1 repeats the flash with busy held high.
        bus_a.act = 2'b10;
        for (int j = 0; j < 24; j++) begin
            cycle();
            if (j >= 1) check_val("cont_busy", 32'(bus_a.busy[1]), 32'h1);
        end
        settle(14);

        // Pending: one pulse during ON and one during GAP give exactly one extra flash.
        lit_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            bus_a.act = (j == 0 || j == 2 || j == 5) ? 2'b01 : 2'b00;
            cycle();
            lit_cnt += int'(bus_a.led[0] ^ 1'b1);
        end
        check_val("pend_lit_cycles", 32'(lit_cnt), 32'd8);
        check_val("pend_idle", 32'(bus_a.busy[0]), 32'h0);

        // Breathe at known counter values, then gate forces dark.
        bus_a.mode = 4'b1010;
        bus_a.gate = 2'b11;
        for (int j = 0; j < 40; j++) begin
            c = mcnt[0];
            cycle();
            if (c == 6)  check_val("breathe_06", 32'(bus_a.led[0] ^ 1'b1), 32'h0);
            if (c == 9)  check_val("breathe_09", 32'(bus_a.led[0] ^ 1'b1), 32'h1);
            if (c == 22) check_val("breathe_22", 32'(bus_a.led[1] ^ 1'b1), 32'h1);
        end
        bus_a.gate = 2'b00;
        for (int j = 0; j < 6; j++) begin
            cycle();
            if (j >= 1) check_val("gate_dark", 32'(bus_a.led), 32'h3);
        end
        bus_a.gate = 2'b11;

        // Reset in the middle of ON: dark and idle immediately, no flash resumes.
        bus_a.mode = 4'b1111;
        settle(12);
        bus_a.act = 2'b01;
        cycle();
        bus_a.act = 2'b00;
        cycle();
        check_val("mid_on_lit", 32'(bus_a.led[0] ^ 1'b1), 32'h1);
        reset = 1'b1;
        cycle();
        check_val("mid_rst_led",  32'(bus_a.led),  32'h3);
        check_val("mid_rst_busy", 32'(bus_a.busy), 32'h0);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cycle();
            check_val("post_rst_busy", 32'(bus_a.busy), 32'h0);
        end

        // Random traffic on both instances with occasional resets.
        for (int j = 0; j < 800; j++) begin
            bus_a.mode = 4'($urandom);
            bus_a.act  = 2'($urandom_range(0, 3) & $urandom_range(0, 3) & $urandom_range(0, 3));
            bus_a.gate = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            reset      = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        settle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_activity_ctrl.md
LED_ACTIVITY_CTRL -- requirements
Module: led_activity_ctrl

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent LED channels (1..8).
REQ-002 Parameter PWM_W, default 8: brightness/PWM resolution in bits.
REQ-003 Parameter CNT_W, default 27: free-running counter width; legal only when CNT_W >= 2*PWM_W+1.
REQ-004 Parameter ON_LEN, default 1000000: activity flash length in cycles (>=1).
REQ-005 Parameter GAP_LEN, default 500000: forced dark gap after each flash in cycles (>=1).
REQ-006 Parameter ACTIVE_LOW, default 0: 1 inverts every led output bit.
REQ-007 clk_sys  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 mode  in  2*CHANNELS  per channel i at bits [2i+1:2i]: 00 off, 01 solid on, 10 breathe, 11 activity.
REQ-010 act  in  CHANNELS  per-channel activity event, sampled every cycle, level or pulse.
REQ-011 gate  in  CHANNELS  per-channel enable; 0 forces the LED dark.
REQ-012 led  out  CHANNELS  registered LED drive, polarity per ACTIVE_LOW.
REQ-013 busy  out  CHANNELS  registered; 1 while channel activity FSM is not IDLE.

Function
REQ-014 One shared CNT_W-bit counter cnt SHALL increment by 1 every cycle, wrapping from all-ones to 0.
REQ-015 Breathe level SHALL be bright = cnt[CNT_W-2 -: PWM_W], pwm = cnt[PWM_W-1:0], phase = cnt[CNT_W-1].
REQ-016 Breathe lit SHALL be (bright > pwm) when phase=0 and (bright <= pwm) when phase=1, unsigned compares; all breathing channels are in phase.
REQ-017 Each channel SHALL have an FSM with states IDLE, ON, GAP, a down-counter sized for max(ON_LEN,GAP_LEN)-1, and a pending flag.
REQ-018 IDLE: act=1 -> ON, counter loaded ON_LEN-1; otherwise stay.
REQ-019 ON: counter decrements each cycle; at 0 -> GAP with counter loaded GAP_LEN-1; ON lasts exactly ON_LEN cycles.
REQ-020 GAP: counter decrements; at 0 -> ON (reload ON_LEN-1, clear pending) if pending=1 or act=1 that cycle, else -> IDLE; GAP lasts exactly GAP_LEN cycles.
REQ-021 act=1 while in ON or GAP (excluding the GAP exit cycle) SHALL set pending; multiple events collapse into one flash; act never restarts or extends a running ON.
REQ-022 FSMs SHALL run in every mode; mode only selects what drives led.
REQ-023 Lit function per channel: mode 00 -> 0; 01 -> 1; 10 -> breathe lit; 11 -> (state==ON).
REQ-024 led[i] SHALL be registered: led[i] <= (gate[i] & lit_i) XOR ACTIVE_LOW, lit_i computed from the current-cycle state and cnt.
REQ-025 Latency: act=1 sampled at edge N in IDLE -> state ON after edge N; led active after edge N+1; busy=1 after edge N+1.
REQ-026 busy[i] <= (state_i != IDLE), registered like led.
REQ-027 mode and gate changes SHALL affect led one cycle later and SHALL NOT disturb FSM, counter or cnt state.
REQ-028 gate=0 SHALL NOT clear pending or stop the FSM.

Reset
REQ-029 reset=1 at an edge SHALL set cnt=0, every FSM to IDLE, down-counters and pending to 0, busy=0, led=ACTIVE_LOW for all bits.
REQ-030 reset SHALL override act, mode and gate in the same cycle, including mid-ON and mid-GAP; no flash resumes after release.
REQ-031 First cycle after reset release SHALL behave as IDLE with cnt=0 (cnt=1 after that edge).

Verification
REQ-032 Reset: hold reset 3 cycles, ACTIVE_LOW=1 -> led=all ones, busy=0; cnt=0 at release.
REQ-033 Single flash, ON_LEN=4, GAP_LEN=2, mode=11, gate=1: act 1-cycle pulse at edge N -> led=1 after edges N+1..N+4, led=0 after N+5, N+6, busy=0 after N+7.
REQ-034 Continuous act=1 with same params -> repeating pattern 4 cycles lit / 2 dark, busy held 1.
REQ-035 Pending: pulse during ON plus one pulse during GAP -> exactly one extra 4-cycle flash after the gap, then IDLE.
REQ-036 Breathe, PWM_W=2, CNT_W=5, mode=10: cnt=5'b00110 -> led 0 next cycle; cnt=5'b01001 -> 1; cnt=5'b10110 -> 1 (phase 1, 1<=2); gate=0 -> 0.
REQ-037 Reset mid-ON at ON cycle 2 -> led inactive and busy=0 after that edge; no further flash without a new act.
